// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: hazard and sequencing controller for the fetch/decode
// pipeline feeding ID_EX. Resolves taken branches, load-use hazards and a
// not-ready instruction memory by fixed priority, and runs the post-reset
// pipeline fill.
// Optional build macro: FETCH_PIPE_CTRL_STATS_EN adds the saturating
// STALL_COUNT / FLUSH_COUNT statistics outputs.
module fetch_pipe_ctrl #(
  parameter int unsigned REG_BITS    = 5,
  parameter int unsigned FILL_CYCLES = 2
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [REG_BITS-1:0] IF_ID_RS,
  input  logic [REG_BITS-1:0] IF_ID_RT,
  input  logic                IF_ID_USES_RT,
  input  logic                ID_EX_MEMREAD,
  input  logic [REG_BITS-1:0] ID_EX_RT,
  input  logic                EX_BRANCH_TAKEN,
  input  logic                IMEM_READY,
  output logic                PC_WRITE,
  output logic                IF_ID_WRITE,
  output logic                IF_ID_FLUSH,
  output logic                ID_EX_BUBBLE,
  output logic                FETCH_REQ,
  output logic [2:0]          CTRL_STATE
`ifdef FETCH_PIPE_CTRL_STATS_EN
  ,
  output logic [15:0]         STALL_COUNT,
  output logic [15:0]         FLUSH_COUNT
`endif
);

  localparam int unsigned CNT_W = (FILL_CYCLES < 2) ? 1 : $clog2(FILL_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_FILL       = 3'd0,
    ST_RUN        = 3'd1,
    ST_LOAD_STALL = 3'd2,
    ST_FLUSH      = 3'd3,
    ST_MEM_WAIT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;

  logic load_use_c;
  logic pc_write_c;
  logic if_id_write_c;
  logic if_id_flush_c;
  logic id_ex_bubble_c;
  logic fetch_req_c;

  // Load in EX writes a register the decode instruction reads (r0 never hazards)
  assign load_use_c = ID_EX_MEMREAD && (ID_EX_RT != '0) &&
                      ((ID_EX_RT == IF_ID_RS) || (IF_ID_USES_RT && (ID_EX_RT == IF_ID_RT)));

  // State and fill counter registers
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_FILL;
      fill_q  <= CNT_W'(FILL_CYCLES);
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state and same-cycle hazard response decode
  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    pc_write_c     = 1'b0;
    if_id_write_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    fetch_req_c    = 1'b0;

    case (state_q)
      ST_FILL: begin
        id_ex_bubble_c = 1'b1;
        fetch_req_c    = 1'b1;
        pc_write_c     = IMEM_READY;
        if_id_write_c  = IMEM_READY;
        if (IMEM_READY) begin
          fill_d = fill_q - CNT_W'(1);
          if (fill_q == CNT_W'(1)) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        fetch_req_c = 1'b1;
        if (EX_BRANCH_TAKEN) begin
          pc_write_c     = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          fetch_req_c    = 1'b0;
          state_d        = ST_FLUSH;
        end else if (load_use_c) begin
          id_ex_bubble_c = 1'b1;
          state_d        = ST_LOAD_STALL;
        end else if (!IMEM_READY) begin
          if_id_flush_c = 1'b1;
          state_d       = ST_MEM_WAIT;
        end else begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
        end
      end

      // ID_EX already holds a bubble here, so only memory readiness matters
      ST_LOAD_STALL, ST_FLUSH: begin
        fetch_req_c = 1'b1;
        if (IMEM_READY) begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          state_d       = ST_RUN;
        end else begin
          if_id_flush_c = 1'b1;
          state_d       = ST_MEM_WAIT;
        end
      end

      ST_MEM_WAIT: begin
        fetch_req_c = 1'b1;
        if (EX_BRANCH_TAKEN) begin
          pc_write_c     = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          fetch_req_c    = 1'b0;
          state_d        = ST_FLUSH;
        end else if (IMEM_READY) begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          state_d       = ST_RUN;
        end else begin
          if_id_flush_c = 1'b1;
        end
      end

      default: begin
        state_d = ST_FILL;
        fill_d  = CNT_W'(FILL_CYCLES);
      end
    endcase

    // A flushed IF/ID must never also be loaded
    if (if_id_flush_c) if_id_write_c = 1'b0;
  end

  // Outputs are held low for as long as reset is asserted
  assign PC_WRITE     = pc_write_c     & ~RESET;
  assign IF_ID_WRITE  = if_id_write_c  & ~RESET;
  assign IF_ID_FLUSH  = if_id_flush_c  & ~RESET;
  assign ID_EX_BUBBLE = id_ex_bubble_c & ~RESET;
  assign FETCH_REQ    = fetch_req_c    & ~RESET;
  assign CTRL_STATE   = RESET ? 3'd0 : 3'(state_q);

`ifdef FETCH_PIPE_CTRL_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating stall / redirect statistics (redirect is the only PC_WRITE+FLUSH case)
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if ((state_q != ST_FILL) && !pc_write_c && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (pc_write_c && if_id_flush_c && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign STALL_COUNT = stall_cnt_q;
  assign FLUSH_COUNT = flush_cnt_q;
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Self-checking bench for fetch_pipe_ctrl: directed vector table, hand-written
// reset/fill/mem-wait sequences, and randomized traffic against a rule model.
module tb_fetch_pipe_ctrl;

  localparam int unsigned RB = 5;
  localparam int unsigned FC = 2;

  logic          CLOCK, RESET;
  logic [RB-1:0] IF_ID_RS, IF_ID_RT, ID_EX_RT;
  logic          IF_ID_USES_RT, ID_EX_MEMREAD, EX_BRANCH_TAKEN, IMEM_READY;
  logic          PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, FETCH_REQ;
  logic [2:0]    CTRL_STATE;
`ifdef FETCH_PIPE_CTRL_STATS_EN
  logic [15:0]   STALL_COUNT, FLUSH_COUNT;
`endif

  int n_pass  = 0;
  int n_total = 0;

  fetch_pipe_ctrl #(.REG_BITS(RB), .FILL_CYCLES(FC)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .IF_ID_RS(IF_ID_RS), .IF_ID_RT(IF_ID_RT), .IF_ID_USES_RT(IF_ID_USES_RT),
    .ID_EX_MEMREAD(ID_EX_MEMREAD), .ID_EX_RT(ID_EX_RT),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .IMEM_READY(IMEM_READY),
    .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_BUBBLE(ID_EX_BUBBLE), .FETCH_REQ(FETCH_REQ), .CTRL_STATE(CTRL_STATE)
`ifdef FETCH_PIPE_CTRL_STATS_EN
    , .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
`endif
  );

  // Posedges at 10, 20, ...; inputs change on negedges, outputs sampled 1 ns later
  initial begin
    CLOCK = 1'b1;
    forever #5 CLOCK = ~CLOCK;
  end

  // Expected bundle layout: {pc_write, if_id_write, flush, bubble, fetch_req, state[2:0]}
  typedef struct {
    logic [RB-1:0] rs, rt;
    logic          uses, memr;
    logic [RB-1:0] exrt;
    logic          br, rdy;
    logic [7:0]    exp;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(int rs, int rt, bit uses, bit memr, int exrt, bit br, bit rdy,
                              logic [7:0] exp);
    vec_t v;
    v.rs = RB'(rs); v.rt = RB'(rt); v.uses = uses; v.memr = memr;
    v.exrt = RB'(exrt); v.br = br; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, FETCH_REQ, CTRL_STATE};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(int rs, int rt, bit uses, bit memr, int exrt, bit br, bit rdy);
    IF_ID_RS = RB'(rs); IF_ID_RT = RB'(rt); IF_ID_USES_RT = uses;
    ID_EX_MEMREAD = memr; ID_EX_RT = RB'(exrt); EX_BRANCH_TAKEN = br; IMEM_READY = rdy;
  endtask

  // One cycle: wait for the negedge, apply inputs, check the same-cycle decode
  task automatic step(string name, int rs, int rt, bit uses, bit memr, int exrt, bit br,
                      bit rdy, logic [7:0] exp);
    @(negedge CLOCK);
    drive(rs, rt, uses, memr, exrt, br, rdy);
    #1 check(name, 32'(outs()), 32'(exp));
  endtask

  // Reference model state (states named by the published debug encoding)
  localparam int M_FILL = 0, M_RUN = 1, M_LSTALL = 2, M_FLUSH = 3, M_WAIT = 4;
  int m_st, m_fill, m_stall, m_redir;

  task automatic model_reset();
    m_st = M_FILL; m_fill = FC; m_stall = 0; m_redir = 0;
  endtask

  // Predict outputs for current inputs, then advance the model over the clock edge
  task automatic model_cycle(output logic [7:0] exp);
    bit lu, redirect, stall, waitm;
    logic pcw, ifw, fl, bub, req;
    if (RESET) begin
      exp = 8'd0;
      model_reset();
      return;
    end
    if (m_st == M_FILL) begin
      exp = {IMEM_READY, IMEM_READY, 1'b0, 1'b1, 1'b1, 3'd0};
      if (IMEM_READY) begin
        if (m_fill == 1) m_st = M_RUN;
        m_fill--;
      end
      return;
    end
    lu = ID_EX_MEMREAD && (ID_EX_RT != 0) &&
         ((ID_EX_RT == IF_ID_RS) || (IF_ID_USES_RT && ID_EX_RT == IF_ID_RT));
    redirect = EX_BRANCH_TAKEN && (m_st == M_RUN || m_st == M_WAIT);
    stall    = !redirect && lu && (m_st == M_RUN);
    waitm    = !redirect && !stall && !IMEM_READY;
    pcw = redirect || (!stall && !waitm);
    ifw = !redirect && !stall && !waitm;
    fl  = redirect || waitm;
    bub = redirect || stall;
    req = !redirect;
    exp = {pcw, ifw, fl, bub, req, 3'(m_st)};
    if (!pcw && m_stall < 16'hFFFF) m_stall++;
    if (redirect && m_redir < 16'hFFFF) m_redir++;
    if (redirect)   m_st = M_FLUSH;
    else if (stall) m_st = M_LSTALL;
    else if (waitm) m_st = M_WAIT;
    else            m_st = M_RUN;
  endtask

  initial begin
    logic [7:0] e;
    // rs rt uses memr exrt br rdy  expected
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 8'b11011_000);  // fill 1
    tbl[1]  = mk(5, 0, 0, 1, 5, 1, 1, 8'b11011_000);  // fill 2, branch+hazard ignored
    tbl[2]  = mk(5, 0, 0, 1, 5, 0, 1, 8'b00011_001);  // load-use on RS
    tbl[3]  = mk(5, 0, 0, 1, 5, 0, 1, 8'b11001_010);  // one-cycle stall then issue
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 1, 8'b11001_001);  // r0 never hazards
    tbl[5]  = mk(3, 7, 0, 1, 7, 0, 1, 8'b11001_001);  // RT match but RT unused
    tbl[6]  = mk(3, 7, 1, 1, 7, 0, 1, 8'b00011_001);  // RT match and used
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 8'b00101_010);  // stall exits into mem wait
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 8'b00101_100);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 8'b11001_100);  // ready releases wait
    tbl[10] = mk(5, 0, 0, 1, 5, 1, 1, 8'b10110_001);  // branch beats load-use
    tbl[11] = mk(5, 0, 0, 1, 5, 1, 1, 8'b11001_011);  // FLUSH ignores both
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 8'b00101_001);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 8'b00101_100);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 8'b10110_100);  // branch abandons wait
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 8'b00101_011);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 8'b11001_100);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 8'b11001_001);

    // Reset held for 15 ns with memory ready and a branch pending
    RESET = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 1);
    #1  check("reset_outs_t1", 32'(outs()), 32'd0);
    #10 check("reset_outs_t11", 32'(outs()), 32'd0);

    @(negedge CLOCK);
    RESET = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i != 0) @(negedge CLOCK);
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].memr, tbl[i].exrt, tbl[i].br, tbl[i].rdy);
      #1 check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Reset mid-run drops outputs at once; fill restarts with full count
    @(negedge CLOCK);
    drive(0, 0, 0, 0, 0, 0, 1);
    RESET = 1'b1;
    #1 check("midrun_reset", 32'(outs()), 32'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    #1 check("refill_1", 32'(outs()), 32'(8'b11011_000));
    step("refill_stall", 0, 0, 0, 0, 0, 0, 0, 8'b00011_000);
    step("refill_2", 0, 0, 0, 0, 0, 0, 1, 8'b11011_000);
    step("refill_done", 0, 0, 0, 0, 0, 0, 1, 8'b11001_001);

    // Three not-ready cycles in RUN, then resume
    step("mw_1", 0, 0, 0, 0, 0, 0, 0, 8'b00101_001);
    step("mw_2", 0, 0, 0, 0, 0, 0, 0, 8'b00101_100);
    step("mw_3", 0, 0, 0, 0, 0, 0, 0, 8'b00101_100);
    step("mw_ready", 0, 0, 0, 0, 0, 0, 1, 8'b11001_100);
    step("mw_back_run", 0, 0, 0, 0, 0, 0, 1, 8'b11001_001);

`ifdef FETCH_PIPE_CTRL_STATS_EN
    // Four stall cycles and one redirect from a fresh reset
    @(negedge CLOCK);
    RESET = 1'b1;
    #1 check("stats_clear_stall", 32'(STALL_COUNT), 32'd0);
    check("stats_clear_flush", 32'(FLUSH_COUNT), 32'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    step("st_fill2", 0, 0, 0, 0, 0, 0, 1, 8'b11011_000);
    step("st_s1", 0, 0, 0, 0, 0, 0, 0, 8'b00101_001);
    step("st_s2", 0, 0, 0, 0, 0, 0, 0, 8'b00101_100);
    step("st_go", 0, 0, 0, 0, 0, 0, 1, 8'b11001_100);
    step("st_s3", 4, 0, 0, 1, 4, 0, 1, 8'b00011_001);
    step("st_s4", 0, 0, 0, 0, 0, 0, 0, 8'b00101_010);
    step("st_br", 0, 0, 0, 0, 0, 1, 0, 8'b10110_100);
    step("st_run", 0, 0, 0, 0, 0, 0, 1, 8'b11001_011);
    #1 check("stall_count", 32'(STALL_COUNT), 32'd4);
    check("flush_count", 32'(FLUSH_COUNT), 32'd1);
`endif

    // Randomized traffic against the rule model
    @(negedge CLOCK);
    RESET = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    #1 model_cycle(e);
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLOCK);
      RESET = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0));
      #1 model_cycle(e);
      check($sformatf("rand%0d", c), 32'(outs()), 32'(e));
    end
`ifdef FETCH_PIPE_CTRL_STATS_EN
    @(negedge CLOCK);
    RESET = 1'b0;
    #1 check("rand_stall_count", 32'(STALL_COUNT), 32'(m_stall));
    check("rand_flush_count", 32'(FLUSH_COUNT), 32'(m_redir));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
